// File: rtl/onehot_bitscan_iter_if.sv
// Handshake bundle for onehot_bitscan_iter: bitmap input stream, index output stream
// and status flags. The out_last signal exists only when ONEHOT_BITSCAN_LAST_EN is defined.
// master: the side that supplies bitmaps and consumes indices.
// slave:  the bit-scanner itself.
interface onehot_bitscan_iter_if #(
    parameter int N  = 16,
    parameter int LN = $clog2(N)
) ();
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [LN-1:0] out_index;
    logic          empty_drop;
    logic          busy;
`ifdef ONEHOT_BITSCAN_LAST_EN
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, empty_drop, busy, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, empty_drop, busy, out_last
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, empty_drop, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, empty_drop, busy
    );
`endif
endinterface

// File: rtl/onehot_bitscan_iter.sv
// onehot_bitscan_iter: accepts an N-bit request bitmap and streams out the index of every
// set bit, one per cycle, lowest-first (REVERSE=0) or highest-first (REVERSE=1).
// Optional feature macro: ONEHOT_BITSCAN_LAST_EN adds out_last, flagging the final
// index of each bitmap. Without the macro no last-detect logic is built.
module onehot_bitscan_iter #(
    parameter int N       = 16,
    parameter int REVERSE = 0,
    parameter int LN      = $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    onehot_bitscan_iter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO_N = {N{1'b0}};

    state_t        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          empty_drop_q, empty_drop_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          out_valid_s;
    logic [LN-1:0] scan_idx_s;
    logic [N-1:0]  rem_clr_s;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [LN-1:0] lowest_idx(input logic [N-1:0] v);
        logic [LN-1:0] res;
        res = {LN{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = LN'(i);
            end
        end
        return res;
    endfunction

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [LN-1:0] highest_idx(input logic [N-1:0] v);
        logic [LN-1:0] res;
        res = {LN{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                res = LN'(i);
            end
        end
        return res;
    endfunction

    // Handshake qualifiers; reset forces everything quiet.
    always_comb begin
        in_ready_s  = !reset_i && (state_q == ST_IDLE);
        out_valid_s = !reset_i && (state_q == ST_SCAN);
        accept_s    = bus.in_valid && in_ready_s;
    end

    // Scan position comes from the remaining-bits register only, so it is stable under stall.
    always_comb begin
        if (REVERSE != 0) begin
            scan_idx_s = highest_idx(rem_q);
        end else begin
            scan_idx_s = lowest_idx(rem_q);
        end
        rem_clr_s = rem_q & ~(ONE_N << scan_idx_s);
    end

    // Next-state logic: accept bitmaps in IDLE, retire one bit per transfer in SCAN.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        empty_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.in_data != ZERO_N) begin
                        rem_d   = bus.in_data;
                        state_d = ST_SCAN;
                    end else begin
                        empty_drop_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.out_ready) begin
                    rem_d = rem_clr_s;
                    if (rem_clr_s == ZERO_N) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = ZERO_N;
            end
        endcase
    end

    // State, remaining bits and drop pulse registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            rem_q        <= ZERO_N;
            empty_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            empty_drop_q <= empty_drop_d;
        end
    end

    // Output drive; the index is forced to zero whenever it is not valid.
    always_comb begin
        bus.in_ready   = in_ready_s;
        bus.out_valid  = out_valid_s;
        bus.busy       = out_valid_s;
        bus.empty_drop = empty_drop_q && !reset_i;
        if (out_valid_s) begin
            bus.out_index = scan_idx_s;
        end else begin
            bus.out_index = {LN{1'b0}};
        end
    end

`ifdef ONEHOT_BITSCAN_LAST_EN
    // Final index of a bitmap: exactly one bit remains.
    always_comb begin
        bus.out_last = out_valid_s && (rem_q != ZERO_N) && ((rem_q & (rem_q - ONE_N)) == ZERO_N);
    end
`endif

endmodule

// File: tb/tb_onehot_bitscan_iter.sv
// Directed testbench for onehot_bitscan_iter: one forward (REVERSE=0) and one reverse
// (REVERSE=1) instance share the same stimulus; each scenario task checks inline.
module tb_onehot_bitscan_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_ready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    onehot_bitscan_iter_if #(.N(16)) fwd_if ();
    onehot_bitscan_iter_if #(.N(16)) rev_if ();

    assign fwd_if.in_valid  = in_valid;
    assign fwd_if.in_data   = in_data;
    assign fwd_if.out_ready = out_ready;
    assign rev_if.in_valid  = in_valid;
    assign rev_if.in_data   = in_data;
    assign rev_if.out_ready = out_ready;

    onehot_bitscan_iter #(.N(16), .REVERSE(0)) dut_fwd (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (fwd_if.slave)
    );

    onehot_bitscan_iter #(.N(16), .REVERSE(1)) dut_rev (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (rev_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (fwd_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", fwd_if.in_ready); end
        tests_run++;
        if (fwd_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", fwd_if.out_valid); end
        tests_run++;
        if (fwd_if.out_index !== 4'd0) begin tests_failed++; $display("FAIL reset_out_index got=%0d exp=0", fwd_if.out_index); end
        tests_run++;
        if (fwd_if.busy !== 1'b0 || rev_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b/%b exp=0/0", fwd_if.busy, rev_if.busy); end
        tests_run++;
        if (fwd_if.empty_drop !== 1'b0) begin tests_failed++; $display("FAIL reset_empty_drop got=%b exp=0", fwd_if.empty_drop); end
`ifdef ONEHOT_BITSCAN_LAST_EN
        tests_run++;
        if (fwd_if.out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got=%b exp=0", fwd_if.out_last); end
`endif
        reset = 1'b0;
        #1;
        tests_run++;
        if (fwd_if.in_ready !== 1'b1 || rev_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got=%b/%b exp=1/1", fwd_if.in_ready, rev_if.in_ready); end
    endtask

    // 16'h8421 streamed from the forward instance: 0,5,10,15.
    task automatic test_forward();
        logic [3:0] exp_idx [4];
        exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
        in_data = 16'h8421;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = 16'h0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== exp_idx[i] || fwd_if.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL fwd_stream[%0d] got valid=%b idx=%0d busy=%b exp valid=1 idx=%0d busy=1", i, fwd_if.out_valid, fwd_if.out_index, fwd_if.busy, exp_idx[i]);
            end
            tests_run++;
            if (fwd_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL fwd_in_ready_scan[%0d] got=%b exp=0", i, fwd_if.in_ready); end
`ifdef ONEHOT_BITSCAN_LAST_EN
            tests_run++;
            if (fwd_if.out_last !== (i == 3)) begin tests_failed++; $display("FAIL fwd_out_last[%0d] got=%b exp=%b", i, fwd_if.out_last, (i == 3)); end
`endif
            tick();
        end
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_done got valid=%b ready=%b exp valid=0 ready=1", fwd_if.out_valid, fwd_if.in_ready);
        end
    endtask

    // Same bitmap from the reverse instance: 15,10,5,0.
    task automatic test_reverse();
        logic [3:0] exp_idx [4];
        exp_idx = '{4'd15, 4'd10, 4'd5, 4'd0};
        in_data = 16'h8421;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = 16'h0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rev_if.out_valid !== 1'b1 || rev_if.out_index !== exp_idx[i]) begin
                tests_failed++;
                $display("FAIL rev_stream[%0d] got valid=%b idx=%0d exp valid=1 idx=%0d", i, rev_if.out_valid, rev_if.out_index, exp_idx[i]);
            end
`ifdef ONEHOT_BITSCAN_LAST_EN
            tests_run++;
            if (rev_if.out_last !== (i == 3)) begin tests_failed++; $display("FAIL rev_out_last[%0d] got=%b exp=%b", i, rev_if.out_last, (i == 3)); end
`endif
            tick();
        end
        tests_run++;
        if (rev_if.out_valid !== 1'b0 || rev_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rev_done got valid=%b ready=%b exp valid=0 ready=1", rev_if.out_valid, rev_if.in_ready);
        end
    endtask

    // 16'h0006 held off by out_ready=0 for 5 cycles; the index must not move.
    task automatic test_stall();
        in_data = 16'h0006;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data = 16'hFFFF;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd1 || rev_if.out_index !== 4'd2) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d] got valid=%b fwd=%0d rev=%0d exp valid=1 fwd=1 rev=2", i, fwd_if.out_valid, fwd_if.out_index, rev_if.out_index);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (fwd_if.out_index !== 4'd1 || rev_if.out_index !== 4'd2) begin tests_failed++; $display("FAIL stall_release0 got fwd=%0d rev=%0d exp fwd=1 rev=2", fwd_if.out_index, rev_if.out_index); end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd2 || rev_if.out_index !== 4'd1) begin
            tests_failed++;
            $display("FAIL stall_release1 got valid=%b fwd=%0d rev=%0d exp valid=1 fwd=2 rev=1", fwd_if.out_valid, fwd_if.out_index, rev_if.out_index);
        end
        tick();
        in_data = 16'h0000;
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.out_index !== 4'd0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_done got valid=%b idx=%0d ready=%b exp valid=0 idx=0 ready=1", fwd_if.out_valid, fwd_if.out_index, fwd_if.in_ready);
        end
    endtask

    // All-zero bitmap: dropped with a single-cycle empty_drop pulse.
    task automatic test_empty();
        in_data = 16'h0000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (fwd_if.empty_drop !== 1'b0) begin tests_failed++; $display("FAIL empty_pre got=%b exp=0", fwd_if.empty_drop); end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (fwd_if.empty_drop !== 1'b1 || fwd_if.out_valid !== 1'b0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_pulse got drop=%b valid=%b ready=%b exp drop=1 valid=0 ready=1", fwd_if.empty_drop, fwd_if.out_valid, fwd_if.in_ready);
        end
        tick();
        tests_run++;
        if (fwd_if.empty_drop !== 1'b0 || fwd_if.out_valid !== 1'b0 || fwd_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_after got drop=%b valid=%b busy=%b exp drop=0 valid=0 busy=0", fwd_if.empty_drop, fwd_if.out_valid, fwd_if.busy);
        end
    endtask

    // Reset in the middle of a 16'hFFFF scan, then a fresh bitmap 16'h0030.
    task automatic test_reset_mid_scan();
        in_data = 16'hFFFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'(i)) begin
                tests_failed++;
                $display("FAIL full_stream[%0d] got valid=%b idx=%0d exp valid=1 idx=%0d", i, fwd_if.out_valid, fwd_if.out_index, i);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.out_index !== 4'd0 || fwd_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_abandon got valid=%b idx=%0d busy=%b exp valid=0 idx=0 busy=0", fwd_if.out_valid, fwd_if.out_index, fwd_if.busy);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_idle got valid=%b ready=%b exp valid=0 ready=1", fwd_if.out_valid, fwd_if.in_ready);
        end
        in_data = 16'h0030;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd4) begin tests_failed++; $display("FAIL fresh_first got valid=%b idx=%0d exp valid=1 idx=4", fwd_if.out_valid, fwd_if.out_index); end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd5) begin tests_failed++; $display("FAIL fresh_second got valid=%b idx=%0d exp valid=1 idx=5", fwd_if.out_valid, fwd_if.out_index); end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL fresh_done got valid=%b exp=0", fwd_if.out_valid); end
    endtask

    // in_valid held across two bitmaps: 0001 then 0003 gives stream 0,0,1.
    task automatic test_back_to_back();
        in_data = 16'h0001;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = 16'h0003;
        #1;
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd0 || fwd_if.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first got valid=%b idx=%0d ready=%b exp valid=1 idx=0 ready=0", fwd_if.out_valid, fwd_if.out_index, fwd_if.in_ready);
        end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap got valid=%b ready=%b exp valid=0 ready=1", fwd_if.out_valid, fwd_if.in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_data = 16'h0000;
        #1;
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd0) begin tests_failed++; $display("FAIL b2b_second0 got valid=%b idx=%0d exp valid=1 idx=0", fwd_if.out_valid, fwd_if.out_index); end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b1 || fwd_if.out_index !== 4'd1) begin tests_failed++; $display("FAIL b2b_second1 got valid=%b idx=%0d exp valid=1 idx=1", fwd_if.out_valid, fwd_if.out_index); end
        tick();
        tests_run++;
        if (fwd_if.out_valid !== 1'b0 || fwd_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done got valid=%b ready=%b exp valid=0 ready=1", fwd_if.out_valid, fwd_if.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_stall();
        test_empty();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
